// File: rtl/calendar_gregorian.sv
// ---------------------------------------------------------------------------
// calendar_gregorian
//
// Date keeper for the digital clock. It holds day, month, a full-width year and
// day-of-week. The date advances once on each rising edge of the daily carry
// from the time-of-day block. In set mode a single field can be incremented by
// hand. A bulk load from the UART command decoder is validated before it is
// written.
//
// Parameters
//   YEAR_W          width of the year counter; the year wraps at 2^YEAR_W
//   FULL_GREGORIAN  1: full Gregorian leap rule, 0: divisible-by-4 only
//   RESET_*         date and day-of-week after reset (dow 0 = Sunday)
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   day_tick        daily carry level; each 0->1 transition is one day
//   set             manual set mode; day_tick is ignored while it is high
//   inc_day/month/year
//                   manual increments; acted on only when exactly one is high
//   load_valid      one-cycle strobe that qualifies load_day/month/year/dow
//   day, month, year, dow
//                   current date (all registered)
//   leap, dim       current year is leap / days in the current month
//   month_carry     pulse when a tick rolls over into a new month
//   year_wrap       pulse when a tick or inc_year wraps the year to 0
//   load_err        pulse when a load is rejected
// ---------------------------------------------------------------------------
module calendar_gregorian #(
    parameter int unsigned YEAR_W         = 12,
    parameter int unsigned FULL_GREGORIAN = 1,
    parameter int unsigned RESET_YEAR     = 2024,
    parameter int unsigned RESET_MONTH    = 2,
    parameter int unsigned RESET_DAY      = 2,
    parameter int unsigned RESET_DOW      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              day_tick,
    input  logic              set,
    input  logic              inc_day,
    input  logic              inc_month,
    input  logic              inc_year,
    input  logic              load_valid,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [2:0]        load_dow,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        dow,
    output logic              leap,
    output logic [4:0]        dim,
    output logic              month_carry,
    output logic              year_wrap,
    output logic              load_err
);

    // -----------------------------------------------------------------------
    // Calendar helpers
    // -----------------------------------------------------------------------

    // The year is widened to 32 bits so the 100/400 tests behave the same for
    // any YEAR_W, even when 400 does not fit in the counter itself.
    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int unsigned yv;
        yv = 32'(y);
        if (FULL_GREGORIAN != 0)
            return ((yv % 4) == 0) && (((yv % 100) != 0) || ((yv % 400) == 0));
        return (yv % 4) == 0;
    endfunction

    function automatic logic [4:0] dim_of(input logic [3:0] m, input logic lp);
        logic [4:0] n;
        case (m)
            4'd2:                       n = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:    n = 5'd30;
            default:                    n = 5'd31;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] dow_next(input logic [2:0] w);
        return (w == 3'd6) ? 3'd0 : w + 3'd1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [4:0]        day_q,   day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q,  year_d;
    logic [2:0]        dow_q,   dow_d;
    logic              tick_prev_q;
    logic              month_carry_q, month_carry_d;
    logic              year_wrap_q,   year_wrap_d;
    logic              load_err_q,    load_err_d;

    // -----------------------------------------------------------------------
    // Combinational helpers on current state and load fields
    // -----------------------------------------------------------------------
    logic              cur_leap;
    logic [4:0]        cur_dim;
    logic              tick_edge;
    logic [4:0]        load_dim;
    logic              load_ok;
    logic [3:0]        month_inc;
    logic [4:0]        month_inc_dim;
    logic [YEAR_W-1:0] year_inc;

    always_comb begin
        cur_leap      = is_leap(year_q);
        cur_dim       = dim_of(month_q, cur_leap);
        tick_edge     = day_tick & ~tick_prev_q;

        load_dim      = dim_of(load_month, is_leap(load_year));
        load_ok       = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                        (load_day != 5'd0) && (load_day <= load_dim) &&
                        (load_dow <= 3'd6);

        month_inc     = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
        month_inc_dim = dim_of(month_inc, cur_leap);
        year_inc      = year_q + YEAR_W'(1);
    end

    // -----------------------------------------------------------------------
    // Next-state: reset > load > set-mode increment > tick
    // -----------------------------------------------------------------------
    always_comb begin
        day_d         = day_q;
        month_d       = month_q;
        year_d        = year_q;
        dow_d         = dow_q;
        month_carry_d = 1'b0;
        year_wrap_d   = 1'b0;
        load_err_d    = 1'b0;

        if (load_valid) begin
            if (load_ok) begin
                day_d   = load_day;
                month_d = load_month;
                year_d  = load_year;
                dow_d   = load_dow;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (set) begin
            // Zero or several increment requests are treated as no request.
            case ({inc_day, inc_month, inc_year})
                3'b100: begin
                    day_d = (day_q >= cur_dim) ? 5'd1 : day_q + 5'd1;
                    dow_d = dow_next(dow_q);
                end
                3'b010: begin
                    month_d = month_inc;
                    if (day_q > month_inc_dim)
                        day_d = month_inc_dim;
                end
                3'b001: begin
                    year_d      = year_inc;
                    year_wrap_d = (year_inc == '0);
                    if ((month_q == 4'd2) && (day_q == 5'd29) && !is_leap(year_inc))
                        day_d = 5'd28;
                end
                default: ;
            endcase
        end else if (tick_edge) begin
            dow_d = dow_next(dow_q);
            if (day_q < cur_dim) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d         = 5'd1;
                month_carry_d = 1'b1;
                if (month_q < 4'd12) begin
                    month_d = month_q + 4'd1;
                end else begin
                    month_d     = 4'd1;
                    year_d      = year_inc;
                    year_wrap_d = (year_inc == '0);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            day_q         <= 5'(RESET_DAY);
            month_q       <= 4'(RESET_MONTH);
            year_q        <= YEAR_W'(RESET_YEAR);
            dow_q         <= 3'(RESET_DOW);
            // Held high so a day_tick already high at release is not an edge.
            tick_prev_q   <= 1'b1;
            month_carry_q <= 1'b0;
            year_wrap_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            day_q         <= day_d;
            month_q       <= month_d;
            year_q        <= year_d;
            dow_q         <= dow_d;
            tick_prev_q   <= day_tick;
            month_carry_q <= month_carry_d;
            year_wrap_q   <= year_wrap_d;
            load_err_q    <= load_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign day         = day_q;
    assign month       = month_q;
    assign year        = year_q;
    assign dow         = dow_q;
    assign leap        = cur_leap;
    assign dim         = cur_dim;
    assign month_carry = month_carry_q;
    assign year_wrap   = year_wrap_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_calendar_gregorian.sv
// ---------------------------------------------------------------------------
// tb_calendar_gregorian
//
// Three instances share one stimulus stream:
//   0: defaults (YEAR_W=12, full Gregorian rule)
//   1: YEAR_W=12, divisible-by-4 leap rule
//   2: YEAR_W=7, full Gregorian rule, reset year 100
// Each instance is checked every cycle against a calendar model that follows
// the date rules in plain integer arithmetic. Directed scenarios also carry
// literal expected dates.
// ---------------------------------------------------------------------------
module tb_calendar_gregorian;

    localparam int YWK  [3] = '{12, 12, 7};
    localparam int FGK  [3] = '{1, 0, 1};
    localparam int RSTY [3] = '{2024, 2024, 100};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        day_tick = 1'b0;
    logic        set = 1'b0;
    logic        inc_day = 1'b0, inc_month = 1'b0, inc_year = 1'b0;
    logic        load_valid = 1'b0;
    logic [4:0]  load_day = '0;
    logic [3:0]  load_month = '0;
    logic [11:0] load_year = '0;
    logic [2:0]  load_dow = '0;

    logic [4:0]  o_day   [3];
    logic [3:0]  o_month [3];
    logic [2:0]  o_dow   [3];
    logic        o_leap  [3];
    logic [4:0]  o_dim   [3];
    logic        o_mc    [3];
    logic        o_yw    [3];
    logic        o_le    [3];
    logic [11:0] o_year0, o_year1;
    logic [6:0]  o_year2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calendar_gregorian dut0 (
        .clk(clk), .reset(reset), .day_tick(day_tick), .set(set),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year),
        .load_valid(load_valid), .load_day(load_day), .load_month(load_month),
        .load_year(load_year), .load_dow(load_dow),
        .day(o_day[0]), .month(o_month[0]), .year(o_year0), .dow(o_dow[0]),
        .leap(o_leap[0]), .dim(o_dim[0]), .month_carry(o_mc[0]),
        .year_wrap(o_yw[0]), .load_err(o_le[0])
    );

    calendar_gregorian #(.FULL_GREGORIAN(0)) dut1 (
        .clk(clk), .reset(reset), .day_tick(day_tick), .set(set),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year),
        .load_valid(load_valid), .load_day(load_day), .load_month(load_month),
        .load_year(load_year), .load_dow(load_dow),
        .day(o_day[1]), .month(o_month[1]), .year(o_year1), .dow(o_dow[1]),
        .leap(o_leap[1]), .dim(o_dim[1]), .month_carry(o_mc[1]),
        .year_wrap(o_yw[1]), .load_err(o_le[1])
    );

    calendar_gregorian #(.YEAR_W(7), .RESET_YEAR(100)) dut2 (
        .clk(clk), .reset(reset), .day_tick(day_tick), .set(set),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year),
        .load_valid(load_valid), .load_day(load_day), .load_month(load_month),
        .load_year(load_year[6:0]), .load_dow(load_dow),
        .day(o_day[2]), .month(o_month[2]), .year(o_year2), .dow(o_dow[2]),
        .leap(o_leap[2]), .dim(o_dim[2]), .month_carry(o_mc[2]),
        .year_wrap(o_yw[2]), .load_err(o_le[2])
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int d, m, y, w;
        bit prev, mc, yw, le;
    } mstate_t;

    mstate_t mdl [3];

    function automatic bit m_leap(int y, int fg);
        if (fg != 0) return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
        return y % 4 == 0;
    endfunction

    function automatic int m_dim(int m, int y, int fg);
        int tbl [13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && m_leap(y, fg)) return 29;
        if (m < 1 || m > 12) return 31;
        return tbl[m];
    endfunction

    function automatic mstate_t m_step(mstate_t s0, int k);
        mstate_t s;
        int  ymod, fg, ly, nincs;
        bit  edge_seen;
        s = s0;
        ymod = 1 << YWK[k];
        fg   = FGK[k];
        s.mc = 0; s.yw = 0; s.le = 0;
        if (reset) begin
            s.d = 2; s.m = 2; s.y = RSTY[k]; s.w = 5; s.prev = 1;
            return s;
        end
        edge_seen = day_tick && !s.prev;
        s.prev = day_tick;
        ly = int'(load_year) % ymod;
        nincs = int'(inc_day) + int'(inc_month) + int'(inc_year);
        if (load_valid) begin
            if (load_month >= 1 && load_month <= 12 && load_day >= 1 &&
                int'(load_day) <= m_dim(int'(load_month), ly, fg) && load_dow <= 6) begin
                s.d = int'(load_day); s.m = int'(load_month); s.y = ly; s.w = int'(load_dow);
            end else begin
                s.le = 1;
            end
        end else if (set) begin
            if (nincs == 1) begin
                if (inc_day) begin
                    s.d = (s.d == m_dim(s.m, s.y, fg)) ? 1 : s.d + 1;
                    s.w = (s.w + 1) % 7;
                end else if (inc_month) begin
                    s.m = s.m % 12 + 1;
                    if (s.d > m_dim(s.m, s.y, fg)) s.d = m_dim(s.m, s.y, fg);
                end else begin
                    s.y = (s.y + 1) % ymod;
                    s.yw = (s.y == 0);
                    if (s.m == 2 && s.d == 29 && !m_leap(s.y, fg)) s.d = 28;
                end
            end
        end else if (edge_seen) begin
            s.w = (s.w + 1) % 7;
            if (s.d < m_dim(s.m, s.y, fg)) begin
                s.d++;
            end else begin
                s.d = 1; s.mc = 1;
                if (s.m < 12) s.m++;
                else begin
                    s.m = 1;
                    s.y = (s.y + 1) % ymod;
                    s.yw = (s.y == 0);
                end
            end
        end
        return s;
    endfunction

    function automatic int unsigned year_of(int k);
        if (k == 0) return int'(o_year0);
        if (k == 1) return int'(o_year1);
        return int'(o_year2);
    endfunction

    // Advance one clock with the inputs currently applied, then compare.
    task automatic cyc();
        for (int k = 0; k < 3; k++) mdl[k] = m_step(mdl[k], k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d_day", k),   o_day[k],   mdl[k].d);
            check($sformatf("u%0d_month", k), o_month[k], mdl[k].m);
            check($sformatf("u%0d_year", k),  year_of(k), mdl[k].y);
            check($sformatf("u%0d_dow", k),   o_dow[k],   mdl[k].w);
            check($sformatf("u%0d_leap", k),  o_leap[k],  m_leap(mdl[k].y, FGK[k]));
            check($sformatf("u%0d_dim", k),   o_dim[k],   m_dim(mdl[k].m, mdl[k].y, FGK[k]));
            check($sformatf("u%0d_mcarry", k), o_mc[k],   mdl[k].mc);
            check($sformatf("u%0d_ywrap", k), o_yw[k],    mdl[k].yw);
            check($sformatf("u%0d_lerr", k),  o_le[k],    mdl[k].le);
        end
    endtask

    task automatic do_load(input int d, input int m, input int y, input int w);
        load_valid = 1'b1;
        load_day = 5'(d); load_month = 4'(m); load_year = 12'(y); load_dow = 3'(w);
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic do_tick();
        day_tick = 1'b1;
        cyc();
        day_tick = 1'b0;
        cyc();
    endtask

    task automatic check_date0(input string tag, input int d, input int m, input int y);
        check({tag, "_d"}, o_day[0], d);
        check({tag, "_m"}, o_month[0], m);
        check({tag, "_y"}, o_year0, y);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        check_date0("rst", 2, 2, 2024);
        check("rst_dow", o_dow[0], 5);
        check("rst_year_w7", o_year2, 100);

        // Year rollover by tick
        do_load(31, 12, 2024, 2);
        day_tick = 1'b1;
        cyc();
        check_date0("ny", 1, 1, 2025);
        check("ny_dow", o_dow[0], 3);
        check("ny_mc", o_mc[0], 1);
        check("ny_yw", o_yw[0], 0);
        day_tick = 1'b0;
        cyc();
        check("ny_mc_clear", o_mc[0], 0);

        // Leap rules
        do_load(28, 2, 1900, 0);
        do_tick();
        check_date0("g1900", 1, 3, 1900);
        check("g1900_leap", o_leap[0], 0);
        check("j1900_d", o_day[1], 29);
        check("j1900_m", o_month[1], 2);
        do_load(28, 2, 2000, 0);
        do_tick();
        check_date0("g2000", 29, 2, 2000);

        // Rejected loads leave state unchanged
        do_load(31, 4, 2025, 1);
        check("rej_apr_err", o_le[0], 1);
        check_date0("rej_apr", 29, 2, 2000);
        cyc();
        check("rej_err_clear", o_le[0], 0);
        do_load(29, 2, 2023, 1);
        check("rej_feb_err", o_le[0], 1);
        do_load(1, 1, 2024, 7);
        check("rej_dow_err", o_le[0], 1);
        check_date0("rej_dow", 29, 2, 2000);

        // Set mode
        do_load(31, 1, 2024, 3);
        set = 1'b1;
        inc_month = 1'b1;
        cyc();
        inc_month = 1'b0;
        check_date0("s_month", 29, 2, 2024);
        inc_year = 1'b1;
        cyc();
        inc_year = 1'b0;
        check_date0("s_year", 28, 2, 2025);
        day_tick = 1'b1;
        cyc();
        day_tick = 1'b0;
        check_date0("s_tick", 28, 2, 2025);
        inc_day = 1'b1; inc_month = 1'b1;
        cyc();
        inc_day = 1'b0; inc_month = 1'b0;
        check_date0("s_multi", 28, 2, 2025);
        set = 1'b0;
        cyc();

        // Narrow year wrap
        do_load(31, 12, 127, 0);
        day_tick = 1'b1;
        cyc();
        check("w7_d", o_day[2], 1);
        check("w7_m", o_month[2], 1);
        check("w7_y", o_year2, 0);
        check("w7_mc", o_mc[2], 1);
        check("w7_yw", o_yw[2], 1);
        day_tick = 1'b0;
        cyc();

        // day_tick held high across reset release
        reset = 1'b1; day_tick = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc();
        check_date0("hold", 2, 2, 2024);
        check("hold_dow", o_dow[0], 5);
        day_tick = 1'b0;
        cyc();

        // Reset beats a same-cycle load
        do_tick();
        reset = 1'b1;
        do_load(10, 10, 2010, 1);
        reset = 1'b0;
        check_date0("rst_ld", 2, 2, 2024);
        cyc();

        // Load beats a same-cycle tick edge
        day_tick = 1'b1;
        do_load(15, 6, 2030, 4);
        check_date0("ld_tick", 15, 6, 2030);
        check("ld_tick_dow", o_dow[0], 4);
        day_tick = 1'b0;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            load_valid = ($urandom_range(0, 9) == 0);
            load_day   = 5'($urandom_range(0, 31));
            load_month = 4'($urandom_range(0, 15));
            load_dow   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: load_year = 12'd1900;
                1: load_year = 12'd2000;
                2: load_year = 12'd2100;
                3: load_year = 12'd127;
                4: load_year = 12'd4095;
                default: load_year = 12'($urandom_range(0, 4095));
            endcase
            if ($urandom_range(0, 15) == 0) set = ~set;
            if ($urandom_range(0, 2) == 0)
                {inc_day, inc_month, inc_year} = 3'($urandom_range(0, 7));
            else
                {inc_day, inc_month, inc_year} = 3'b000;
            if ($urandom_range(0, 1) == 0) day_tick = ~day_tick;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
